client_tx_arb: RTL and testbench

// Round-robin arbiter/multiplexer between n_clients Ethernet TX clients (req/ack/strobe/length/data

---
 rtl/client_tx_arb_pkg.sv | 27 ++
 rtl/client_tx_arb_rr_pick.sv | 35 +++
 rtl/client_tx_arb.sv | 148 ++++++++++++++
 tb/tb_client_tx_arb.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/client_tx_arb_pkg.sv
// Shared definitions for the client TX arbiter and the client blocks that talk to it.
// Contents:
//   ST_* constants   FSM state encoding (IDLE=0, REQ=1, WAIT=2, XMIT=3)
//   arb_state_e      typed enum built on those constants
//   JUMBO_DW_DEFAULT default frame-length width (14 = jumbo frames)
//   idx_width()      index width for an n-entry client vector, never below 1
package client_tx_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_XMIT = 2'd3;

  localparam int unsigned JUMBO_DW_DEFAULT = 14;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StReq  = ST_REQ,
    StWait = ST_WAIT,
    StXmit = ST_XMIT
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/client_tx_arb_rr_pick.sv
// Combinational cyclic priority encoder.
// Ports:
//   req  in   n_clients  request vector
//   rr   in   IdxW       pointer: the search starts at this index and wraps
//   idx  out  IdxW       first asserted index at or after rr (cyclic), 0 when none
//   any  out  1          at least one request asserted
module client_tx_arb_rr_pick
  import client_tx_arb_pkg::*;
#(
  parameter int unsigned n_clients = 4,
  parameter int unsigned IdxW      = idx_width(n_clients)
) (
  input  logic [n_clients-1:0] req,
  input  logic [IdxW-1:0]      rr,
  output logic [IdxW-1:0]      idx,
  output logic                 any
);

  logic [IdxW-1:0] cand;
  int              pos;

  // Walk offsets from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    idx  = '0;
    any  = |req;
    cand = '0;
    pos  = 0;
    for (int k = int'(n_clients) - 1; k >= 0; k--) begin
      pos  = (int'(rr) + k) % int'(n_clients);
      cand = IdxW'(pos);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/client_tx_arb.sv
// Round-robin arbiter/multiplexer between n_clients Ethernet TX clients and one downstream TX
// port using the same req/ack/strobe/length/data protocol, so arbiters can be cascaded.
// Ports:
//   clk, rst     TX-domain clock, synchronous active-high reset
//   c_req        per-client frame request, held until ack
//   c_length     per-client frame length, client i at [i*jumbo_dw +: jumbo_dw]
//   c_data       per-client data byte, client i at [i*8 +: 8]
//   c_ack        per-client grant pulse (forwarded downstream ack)
//   c_strobe     per-client warn/data strobe (forwarded downstream strobe)
//   req          request to downstream port
//   ack, strobe  downstream grant pulse and warn/data strobe
//   length       length of the granted frame
//   data_out     selected client's data, 0 while strobe is low
//   len_err      sticky: strobe count of a frame differed from its length
//   tmo_err      sticky: ack->strobe watchdog expired
//   frame_cnt    completed frames, wrapping
module client_tx_arb
  import client_tx_arb_pkg::*;
#(
  parameter int unsigned n_clients = 4,
  parameter int unsigned jumbo_dw  = JUMBO_DW_DEFAULT,
  parameter int unsigned tmo_w     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [n_clients-1:0]          c_req,
  input  logic [n_clients*jumbo_dw-1:0] c_length,
  input  logic [n_clients*8-1:0]        c_data,
  output logic [n_clients-1:0]          c_ack,
  output logic [n_clients-1:0]          c_strobe,
  output logic                          req,
  input  logic                          ack,
  input  logic                          strobe,
  output logic [jumbo_dw-1:0]           length,
  output logic [7:0]                    data_out,
  output logic                          len_err,
  output logic                          tmo_err,
  output logic [15:0]                   frame_cnt
);

  localparam int unsigned IdxW = idx_width(n_clients);
  localparam int unsigned CntW = jumbo_dw + 1;

  arb_state_e       st_q;
  logic [IdxW-1:0]  sel_q;
  logic [IdxW-1:0]  rr_q;
  logic [tmo_w-1:0] wdog_q;
  logic [CntW-1:0]  scnt_q;

  logic [IdxW-1:0]     pick_idx;
  logic                pick_any;
  logic [IdxW-1:0]     rr_next;
  logic [jumbo_dw-1:0] len_arr  [n_clients];
  logic [7:0]          data_arr [n_clients];

  for (genvar i = 0; i < n_clients; i++) begin : g_unpack
    assign len_arr[i]  = c_length[i*jumbo_dw +: jumbo_dw];
    assign data_arr[i] = c_data[i*8 +: 8];
  end

  client_tx_arb_rr_pick #(
    .n_clients (n_clients),
    .IdxW      (IdxW)
  ) u_rr_pick (
    .req (c_req),
    .rr  (rr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The client just served becomes lowest priority.
  assign rr_next = (sel_q == IdxW'(n_clients - 1)) ? '0 : sel_q + IdxW'(1);

  // Grant and strobe are forwarded combinationally so the client sees them in the same cycle
  // as the downstream port; WAIT is included because the first strobe cycle arrives there.
  always_comb begin
    c_ack    = '0;
    c_strobe = '0;
    data_out = '0;
    if (st_q == StReq) c_ack[sel_q] = ack;
    if (st_q == StWait || st_q == StXmit) begin
      c_strobe[sel_q] = strobe;
      if (strobe) data_out = data_arr[sel_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= StIdle;
      sel_q     <= '0;
      rr_q      <= '0;
      wdog_q    <= '0;
      scnt_q    <= '0;
      req       <= 1'b0;
      length    <= '0;
      len_err   <= 1'b0;
      tmo_err   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (st_q)
        StIdle: begin
          if (pick_any) begin
            sel_q  <= pick_idx;
            length <= len_arr[pick_idx];
            req    <= 1'b1;
            st_q   <= StReq;
          end
        end
        StReq: begin
          // Ack beats a simultaneous withdrawal.
          if (ack) begin
            req    <= 1'b0;
            rr_q   <= rr_next;
            wdog_q <= '0;
            st_q   <= StWait;
          end else if (!c_req[sel_q]) begin
            req  <= 1'b0;
            st_q <= StIdle;
          end
        end
        StWait: begin
          if (strobe) begin
            scnt_q <= CntW'(1);
            st_q   <= StXmit;
          end else if (&(wdog_q + tmo_w'(1))) begin
            // Expires on the (2**tmo_w - 1)th strobe-less cycle after ack.
            tmo_err <= 1'b1;
            st_q    <= StIdle;
          end else begin
            wdog_q <= wdog_q + tmo_w'(1);
          end
        end
        StXmit: begin
          if (strobe) begin
            // Saturate so an overlong frame can never wrap back onto a matching count.
            if (scnt_q != '1) scnt_q <= scnt_q + CntW'(1);
          end else begin
            if (scnt_q != {1'b0, length}) len_err <= 1'b1;
            frame_cnt <= frame_cnt + 16'(1);
            st_q      <= StIdle;
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_client_tx_arb.sv
module tb_client_tx_arb;

  localparam int unsigned NC  = 4;
  localparam int unsigned LW  = 14;
  localparam int unsigned TW  = 6;
  localparam int          TMO = (1 << TW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     c_req;
  logic [NC*LW-1:0]  c_length;
  logic [NC*8-1:0]   c_data;
  logic [NC-1:0]     c_ack;
  logic [NC-1:0]     c_strobe;
  logic              req;
  logic              ack;
  logic              strobe;
  logic [LW-1:0]     length;
  logic [7:0]        data_out;
  logic              len_err;
  logic              tmo_err;
  logic [15:0]       frame_cnt;

  client_tx_arb #(
    .n_clients (NC),
    .jumbo_dw  (LW),
    .tmo_w     (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .c_req     (c_req),
    .c_length  (c_length),
    .c_data    (c_data),
    .c_ack     (c_ack),
    .c_strobe  (c_strobe),
    .req       (req),
    .ack       (ack),
    .strobe    (strobe),
    .length    (length),
    .data_out  (data_out),
    .len_err   (len_err),
    .tmo_err   (tmo_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: arbitration pointer, sticky flags, frame count.
  int   m_rr;
  int   m_frames;
  logic m_len_err;
  logic m_tmo_err;
  int   lens [NC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NC-1:0] onehot(input int s);
    logic [NC-1:0] v;
    v = '0;
    v[s[1:0]] = 1'b1;
    return v;
  endfunction

  // First requester at or after the pointer, searching cyclically.
  function automatic int model_pick(input logic [NC-1:0] v, input int rr);
    int j;
    for (int k = 0; k < int'(NC); k++) begin
      j = (rr + k) % int'(NC);
      if (v[j[1:0]]) return j;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_rr      = 0;
    m_frames  = 0;
    m_len_err = 1'b0;
    m_tmo_err = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},       32'(req),       32'd0);
    check({tag, "_length"},    32'(length),    32'd0);
    check({tag, "_c_ack"},     32'(c_ack),     32'd0);
    check({tag, "_c_strobe"},  32'(c_strobe),  32'd0);
    check({tag, "_data_out"},  32'(data_out),  32'd0);
    check({tag, "_len_err"},   32'(len_err),   32'd0);
    check({tag, "_tmo_err"},   32'(tmo_err),   32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  // Entered and left just after a falling edge with the DUT idle.
  task automatic do_reset();
    rst    = 1'b1;
    ack    = 1'b0;
    strobe = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("reset");
  endtask

  // mode: 0 normal frame, 1 withdrawal in REQ, 2 watchdog timeout, 3 reset at byte 100.
  // fixed_len < 0 gives every client a random length; delta skews the strobe count.
  task automatic run_frame(input logic [NC-1:0] vec, input int fixed_len, input int delta,
                           input int mode);
    int         sel;
    int         nstrb;
    logic [7:0] b;
    for (int i = 0; i < int'(NC); i++) begin
      lens[i] = (fixed_len >= 0) ? fixed_len : int'($urandom_range(1, 40));
      c_length[i*LW +: LW] = LW'(lens[i]);
    end
    c_data = $urandom();
    c_req  = vec;
    sel    = model_pick(vec, m_rr);

    @(negedge clk); #1;
    check("req_rise", 32'(req), 32'd1);
    check("length", 32'(length), 32'(lens[sel]));
    check("no_early_ack", 32'(c_ack), 32'd0);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk); #1;
      check("req_hold", 32'(req), 32'd1);
    end

    if (mode == 1) begin
      c_req[sel[1:0]] = 1'b0;
      @(negedge clk); #1;
      check("withdraw_req", 32'(req), 32'd0);
      check("withdraw_ack", 32'(c_ack), 32'd0);
      return;
    end

    ack = 1'b1;
    #1;
    check("grant", 32'(c_ack), 32'(onehot(sel)));
    m_rr = (sel + 1) % int'(NC);
    @(negedge clk);
    ack = 1'b0;
    #1;
    check("req_fall", 32'(req), 32'd0);

    if (mode == 2) begin
      repeat (TMO - 1) @(negedge clk);
      #1;
      check("tmo_not_yet", 32'(tmo_err), 32'(m_tmo_err));
      @(negedge clk);
      m_tmo_err = 1'b1;
      #1;
      check("tmo_err", 32'(tmo_err), 32'(m_tmo_err));
      check("tmo_frames", 32'(frame_cnt), 32'(m_frames));
      return;
    end

    repeat ($urandom_range(0, 4)) begin
      @(negedge clk); #1;
      check("wait_data", 32'(data_out), 32'd0);
    end

    nstrb = lens[sel] + delta;
    if (nstrb < 1) nstrb = 1;
    for (int k = 0; k < nstrb; k++) begin
      b = 8'(k);
      c_data = $urandom();
      c_data[sel*8 +: 8] = b;
      strobe = 1'b1;
      ack = 1'($urandom_range(0, 1));
      #1;
      check("c_strobe", 32'(c_strobe), 32'(onehot(sel)));
      check("data_out", 32'(data_out), 32'(b));
      check("stray_ack", 32'(c_ack), 32'd0);
      if (mode == 3 && k == 100) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("mid_rst");
        strobe = 1'b0;
        ack = 1'b0;
        return;
      end
      @(negedge clk);
    end
    strobe = 1'b0;
    ack = 1'b0;
    #1;
    check("end_strobe", 32'(c_strobe), 32'd0);
    check("end_data", 32'(data_out), 32'd0);
    @(negedge clk);
    if (nstrb != lens[sel]) m_len_err = 1'b1;
    m_frames = (m_frames + 1) % 65536;
    #1;
    check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    check("len_err", 32'(len_err), 32'(m_len_err));
    check("tmo_sticky", 32'(tmo_err), 32'(m_tmo_err));
  endtask

  initial begin
    logic [NC-1:0] vec;
    int            mode;
    int            delta;
    int            r;
    rst      = 1'b1;
    c_req    = '0;
    c_length = '0;
    c_data   = '0;
    ack      = 1'b0;
    strobe   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Single client, 320-byte frame.
    run_frame(4'b0001, 320, 0, 0);

    // Round robin between two held requesters, then a third joins.
    do_reset();
    repeat (4) run_frame(4'b0011, -1, 0, 0);
    repeat (4) run_frame(4'b1011, -1, 0, 0);

    // Withdrawal leaves the pointer where it was.
    run_frame(4'b0100, -1, 0, 1);
    run_frame(4'b0111, -1, 0, 0);

    // Short frame flags len_err; the next frame is still served.
    do_reset();
    run_frame(4'b0001, 320, -1, 0);
    run_frame(4'b0010, -1, 0, 0);

    // Long frame flags len_err.
    do_reset();
    run_frame(4'b0100, -1, 1, 0);

    // Watchdog timeout, then a normal frame.
    do_reset();
    run_frame(4'b0010, -1, 0, 2);
    run_frame(4'b0100, -1, 0, 0);

    // Reset while transmitting byte 100.
    run_frame(4'b1000, 320, 0, 3);
    run_frame(4'b1111, -1, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) do_reset();
      do vec = NC'($urandom()); while (vec == '0);
      r     = int'($urandom_range(0, 19));
      mode  = (r < 2) ? 1 : (r == 2) ? 2 : 0;
      r     = int'($urandom_range(0, 9));
      delta = (r == 0) ? -1 : (r == 1) ? 1 : 0;
      run_frame(vec, -1, delta, mode);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit exceeded");
  end

endmodule
